// File: rtl/eth_sw_nxn.sv
// eth_sw_nxn: N-port packet switch with per-output round-robin arbitration.
//
// Each input presents sop/eop framed packets. The SOP word carries the
// destination output in an 8-bit field at DEST_LSB. A per-output arbiter
// locks one input for the duration of a packet, and each output owns a
// packet FIFO that is drained by rd_en. Packets with invalid destinations
// and words that arrive outside a packet are dropped and counted per input.
//
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   in_data    : input words, port i at [i*DATA_W +: DATA_W]
//   in_valid   : word present per input
//   in_sop     : first word of packet per input
//   in_eop     : last word of packet per input
//   in_stall   : valid word not accepted this cycle (combinational)
//   rd_en      : pop request per output FIFO
//   out_data   : registered popped word per output
//   out_valid  : out_data/out_sop/out_eop valid this cycle
//   out_sop    : popped word is SOP
//   out_eop    : popped word is EOP
//   out_empty  : output FIFO empty
//   err_cnt    : per-input saturating 16-bit drop/error counter
module eth_sw_nxn #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int DEST_LSB   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    input  logic [NUM_PORTS-1:0]        in_valid,
    input  logic [NUM_PORTS-1:0]        in_sop,
    input  logic [NUM_PORTS-1:0]        in_eop,
    output logic [NUM_PORTS-1:0]        in_stall,
    input  logic [NUM_PORTS-1:0]        rd_en,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    output logic [NUM_PORTS-1:0]        out_valid,
    output logic [NUM_PORTS-1:0]        out_sop,
    output logic [NUM_PORTS-1:0]        out_eop,
    output logic [NUM_PORTS-1:0]        out_empty,
    output logic [NUM_PORTS*16-1:0]     err_cnt
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = DATA_W + 2;

    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_t;

    state_t               r_state     [NUM_PORTS];
    state_t               w_stateNext [NUM_PORTS];
    logic [PW-1:0]        r_target    [NUM_PORTS];
    logic [15:0]          r_err       [NUM_PORTS];

    logic [NUM_PORTS-1:0] r_locked;
    logic [PW-1:0]        r_owner     [NUM_PORTS];
    logic [PW-1:0]        r_rr        [NUM_PORTS];

    logic [WW-1:0]        r_mem       [NUM_PORTS][FIFO_DEPTH];
    logic [AW-1:0]        r_wrPtr     [NUM_PORTS];
    logic [AW-1:0]        r_rdPtr     [NUM_PORTS];
    logic [CW-1:0]        r_count     [NUM_PORTS];

    logic [DATA_W-1:0]    r_outData   [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_outValid;
    logic [NUM_PORTS-1:0] r_outSop;
    logic [NUM_PORTS-1:0] r_outEop;

    logic [7:0]           w_dest      [NUM_PORTS];
    logic [PW-1:0]        w_destIdx   [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_destOk;
    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_grantValid;
    logic [PW-1:0]        w_grantIdx  [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_accept;
    logic [NUM_PORTS-1:0] w_errInc;
    logic [NUM_PORTS-1:0] w_wrEn;
    logic [WW-1:0]        w_wrWord    [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_rdEn;

    // Decode the destination field of each input word and raise a request
    // towards an output only for a legal SOP arriving on an idle input.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_dest[i]    = in_data[i*DATA_W + DEST_LSB +: 8];
            w_destIdx[i] = w_dest[i][PW-1:0];
            w_destOk[i]  = (w_dest[i] < 8'(NUM_PORTS));
            w_req[i]     = in_valid[i] & in_sop[i] & w_destOk[i] & (r_state[i] == ST_IDLE);
            w_full[i]    = (r_count[i] == CW'(FIFO_DEPTH));
            w_rdEn[i]    = rd_en[i] & (r_count[i] != '0);
        end
    end

    // Round-robin search per output: the first requester at or after the
    // rr pointer wins, wrapping around NUM_PORTS which need not be a power
    // of two. Only meaningful while the output is unlocked.
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_grantValid[o] = 1'b0;
            w_grantIdx[o]   = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(r_rr[o]) + k;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                if (!w_grantValid[o] && w_req[idx] && (w_destIdx[idx] == PW'(o))) begin
                    w_grantValid[o] = 1'b1;
                    w_grantIdx[o]   = PW'(idx);
                end
            end
        end
    end

    // Acceptance per input. Idle garbage and bad destinations are always
    // swallowed (and counted); a legal SOP needs the grant, an unlocked
    // target and room; forwarding needs room; dropping always accepts.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_accept[i] = 1'b0;
            w_errInc[i] = 1'b0;
            case (r_state[i])
                ST_IDLE: begin
                    if (in_valid[i]) begin
                        if (!in_sop[i] || !w_destOk[i]) begin
                            w_accept[i] = 1'b1;
                            w_errInc[i] = 1'b1;
                        end else begin
                            w_accept[i] = w_grantValid[w_destIdx[i]] &
                                          (w_grantIdx[w_destIdx[i]] == PW'(i)) &
                                          !r_locked[w_destIdx[i]] &
                                          !w_full[w_destIdx[i]];
                        end
                    end
                end
                ST_FWD:  w_accept[i] = in_valid[i] & !w_full[r_target[i]];
                ST_DROP: w_accept[i] = in_valid[i];
                default: w_accept[i] = 1'b0;
            endcase
        end
    end

    // During reset nothing is accepted, so every valid word reports a stall.
    assign in_stall = in_valid & (~w_accept | {NUM_PORTS{rst}});

    // FIFO write mux per output: the lock owner's continuation words (sop
    // cleared, so a stray SOP inside a packet becomes plain data) or the
    // freshly granted SOP word.
    always_comb begin
        int own;
        int g;
        own = 0;
        g   = 0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_wrEn[o]   = 1'b0;
            w_wrWord[o] = '0;
            if (r_locked[o]) begin
                own = int'(r_owner[o]);
                if ((r_state[own] == ST_FWD) && w_accept[own]) begin
                    w_wrEn[o]   = 1'b1;
                    w_wrWord[o] = {in_data[own*DATA_W +: DATA_W], 1'b0, in_eop[own]};
                end
            end else if (w_grantValid[o]) begin
                g = int'(w_grantIdx[o]);
                if (w_accept[g]) begin
                    w_wrEn[o]   = 1'b1;
                    w_wrWord[o] = {in_data[g*DATA_W +: DATA_W], 1'b1, in_eop[g]};
                end
            end
        end
    end

    // Arbiter state: an accepted SOP advances rr past the winner and locks
    // the output unless the packet is a single word; the owner's accepted
    // eop releases the lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_locked <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_owner[o] <= '0;
                r_rr[o]    <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (r_locked[o]) begin
                    if (w_wrEn[o] && w_wrWord[o][0]) begin
                        r_locked[o] <= 1'b0;
                    end
                end else if (w_wrEn[o]) begin
                    r_rr[o] <= (w_grantIdx[o] == PW'(NUM_PORTS - 1)) ? '0 : w_grantIdx[o] + 1'b1;
                    if (!w_wrWord[o][0]) begin
                        r_locked[o] <= 1'b1;
                        r_owner[o]  <= w_grantIdx[o];
                    end
                end
            end
        end
    end

    // Input FSM next state: a multi-word packet moves IDLE to FWD (legal
    // destination) or DROP (illegal one) and returns on its eop.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_stateNext[i] = r_state[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (w_accept[i] && in_sop[i] && !in_eop[i]) begin
                        w_stateNext[i] = w_destOk[i] ? ST_FWD : ST_DROP;
                    end
                end
                ST_FWD: begin
                    if (w_accept[i] && in_eop[i]) begin
                        w_stateNext[i] = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (in_valid[i] && in_eop[i]) begin
                        w_stateNext[i] = ST_IDLE;
                    end
                end
                default: w_stateNext[i] = ST_IDLE;
            endcase
        end
    end

    // Input FSM state, locked target and saturating error counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_state[i]  <= ST_IDLE;
                r_target[i] <= '0;
                r_err[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_state[i] <= w_stateNext[i];
                if ((r_state[i] == ST_IDLE) && w_accept[i] && w_destOk[i]) begin
                    r_target[i] <= w_destIdx[i];
                end
                if (w_errInc[i] && (r_err[i] != 16'hFFFF)) begin
                    r_err[i] <= r_err[i] + 16'd1;
                end
            end
        end
    end

    // FIFO storage has no reset; emptiness is defined by the count alone.
    always_ff @(posedge clk) begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (w_wrEn[o]) begin
                r_mem[o][r_wrPtr[o]] <= w_wrWord[o];
            end
        end
    end

    // FIFO pointers, count and the registered pop stage. Full is judged on
    // the registered count, so a pop never makes room for a same-edge push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= '0;
            r_outSop   <= '0;
            r_outEop   <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_wrPtr[o]   <= '0;
                r_rdPtr[o]   <= '0;
                r_count[o]   <= '0;
                r_outData[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_count[o] <= r_count[o] + CW'(w_wrEn[o]) - CW'(w_rdEn[o]);
                if (w_wrEn[o]) begin
                    r_wrPtr[o] <= r_wrPtr[o] + 1'b1;
                end
                r_outValid[o] <= w_rdEn[o];
                if (w_rdEn[o]) begin
                    r_rdPtr[o]   <= r_rdPtr[o] + 1'b1;
                    r_outData[o] <= r_mem[o][r_rdPtr[o]][WW-1:2];
                    r_outSop[o]  <= r_mem[o][r_rdPtr[o]][1];
                    r_outEop[o]  <= r_mem[o][r_rdPtr[o]][0];
                end else begin
                    r_outSop[o]  <= 1'b0;
                    r_outEop[o]  <= 1'b0;
                end
            end
        end
    end

    // Flatten per-port registers onto the packed output buses.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_data[o*DATA_W +: DATA_W] = r_outData[o];
            out_empty[o]                 = (r_count[o] == '0);
            err_cnt[o*16 +: 16]          = r_err[o];
        end
    end

    assign out_valid = r_outValid;
    assign out_sop   = r_outSop;
    assign out_eop   = r_outEop;

endmodule

// File: tb/tb_eth_sw_nxn.sv
// tb_eth_sw_nxn: scoreboard bench for eth_sw_nxn.
//
// A packet-level reference model (queues per output, lock owner and rr
// pointer per output, packet mode per input) predicts which input words
// are accepted, what lands in each output FIFO and what each pop returns.
// Predicted pops go into per-output expectation queues that an independent
// monitor drains whenever the DUT presents an output word.
module tb_eth_sw_nxn;
    localparam int N     = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int DLSB  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_sop;
    logic [N-1:0]      in_eop;
    logic [N-1:0]      in_stall;
    logic [N-1:0]      rd_en;
    logic [N*DW-1:0]   out_data;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_sop;
    logic [N-1:0]      out_eop;
    logic [N-1:0]      out_empty;
    logic [N*16-1:0]   err_cnt;

    int nTests = 0;
    int nFail  = 0;

    // Reference model state
    logic [DW+1:0] mq   [N][$];
    logic [DW+1:0] expQ [N][$];
    int            mOwner  [N];
    int            mRr     [N];
    int            mMode   [N];
    int            mTarget [N];
    int            mErr    [N];
    logic [N-1:0]  mAccept;

    // Stimulus state
    logic [DW+1:0] pend [N][$];
    logic [N-1:0]  curValid;
    bit            genOn = 1'b0;
    bit            flood = 1'b0;
    int            gapPct = 0;
    int            rdPct  = 0;

    always #5 clk = ~clk;

    eth_sw_nxn #(
        .NUM_PORTS (N),
        .DATA_W    (DW),
        .FIFO_DEPTH(DEPTH),
        .DEST_LSB  (DLSB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_sop   (in_sop),
        .in_eop   (in_eop),
        .in_stall (in_stall),
        .rd_en    (rd_en),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .out_empty(out_empty),
        .err_cnt  (err_cnt)
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelClear();
        for (int o = 0; o < N; o++) begin
            mq[o].delete();
            mOwner[o]  = -1;
            mRr[o]     = 0;
            mMode[o]   = 0;
            mTarget[o] = 0;
            mErr[o]    = 0;
        end
        mAccept = '0;
    endtask

    // One model step: check registered outputs against the state reached so
    // far, predict this cycle's acceptances, then advance to the next edge.
    task automatic modelStep();
        bit            full [N];
        int            win  [N];
        int            d;
        int            idx;
        logic [DW-1:0] dat;
        logic [N-1:0]  acc;
        if (rst) begin
            checkOutput("stall_in_reset", 128'(in_stall), 128'(in_valid));
            checkOutput("empty_reset", 128'(out_empty), 128'({N{1'b1}}));
            checkOutput("errcnt_reset", 128'(err_cnt), 128'(0));
            checkOutput("outdata_reset", 128'(out_data), 128'(0));
            checkOutput("outflags_reset", 128'({out_sop, out_eop}), 128'(0));
            modelClear();
            return;
        end
        for (int o = 0; o < N; o++) begin
            checkOutput($sformatf("out_empty[%0d]", o), 128'(out_empty[o]), 128'(mq[o].size() == 0));
            checkOutput($sformatf("err_cnt[%0d]", o), 128'(err_cnt[o*16 +: 16]), 128'(mErr[o]));
            full[o] = (mq[o].size() >= DEPTH);
            win[o]  = -1;
            if (mOwner[o] < 0) begin
                for (int k = 0; k < N; k++) begin
                    idx = (mRr[o] + k) % N;
                    if (win[o] < 0 && in_valid[idx] && in_sop[idx] && mMode[idx] == 0 &&
                        int'(in_data[idx*DW + DLSB +: 8]) == o) begin
                        win[o] = idx;
                    end
                end
            end
        end
        acc = '0;
        for (int i = 0; i < N; i++) begin
            d = int'(in_data[i*DW + DLSB +: 8]);
            if (in_valid[i]) begin
                case (mMode[i])
                    0: acc[i] = (!in_sop[i] || d >= N) ? 1'b1
                              : (win[d] == i && mOwner[d] < 0 && !full[d]);
                    1: acc[i] = !full[mTarget[i]];
                    default: acc[i] = 1'b1;
                endcase
            end
            checkOutput($sformatf("in_stall[%0d]", i), 128'(in_stall[i]), 128'(in_valid[i] & !acc[i]));
        end
        mAccept = acc;
        for (int o = 0; o < N; o++) begin
            if (rd_en[o] && mq[o].size() > 0) begin
                expQ[o].push_back(mq[o].pop_front());
            end
        end
        for (int i = 0; i < N; i++) begin
            d   = int'(in_data[i*DW + DLSB +: 8]);
            dat = in_data[i*DW +: DW];
            if (in_valid[i]) begin
                if (mMode[i] == 0) begin
                    if (!in_sop[i] || d >= N) begin
                        if (mErr[i] < 16'hFFFF) mErr[i]++;
                        if (in_sop[i] && !in_eop[i]) mMode[i] = 2;
                    end else if (acc[i]) begin
                        mq[d].push_back({dat, 1'b1, in_eop[i]});
                        mRr[d] = (i + 1) % N;
                        if (!in_eop[i]) begin
                            mOwner[d]  = i;
                            mMode[i]   = 1;
                            mTarget[i] = d;
                        end
                    end
                end else if (mMode[i] == 1) begin
                    if (acc[i]) begin
                        mq[mTarget[i]].push_back({dat, 1'b0, in_eop[i]});
                        if (in_eop[i]) begin
                            mOwner[mTarget[i]] = -1;
                            mMode[i] = 0;
                        end
                    end
                end else if (in_eop[i]) begin
                    mMode[i] = 0;
                end
            end
        end
    endtask

    // Model runs just after the falling edge, after the monitor has looked
    // at the outputs, with inputs stable until the next rising edge.
    always @(negedge clk) begin
        #1;
        modelStep();
    end

    // Monitor: whenever a pop was predicted, the DUT must present exactly
    // that word; otherwise out_valid must stay low.
    always @(negedge clk) begin
        logic [DW+1:0] w;
        for (int o = 0; o < N; o++) begin
            if (rst) begin
                checkOutput($sformatf("out_valid_reset[%0d]", o), 128'(out_valid[o]), 128'(0));
                expQ[o].delete();
            end else if (expQ[o].size() > 0) begin
                w = expQ[o].pop_front();
                checkOutput($sformatf("out_valid[%0d]", o), 128'(out_valid[o]), 128'(1));
                checkOutput($sformatf("out_data[%0d]", o), 128'(out_data[o*DW +: DW]), 128'(w[DW+1:2]));
                checkOutput($sformatf("out_sop[%0d]", o), 128'(out_sop[o]), 128'(w[1]));
                checkOutput($sformatf("out_eop[%0d]", o), 128'(out_eop[o]), 128'(w[0]));
            end else begin
                checkOutput($sformatf("out_valid_idle[%0d]", o), 128'(out_valid[o]), 128'(0));
            end
        end
    end

    task automatic pushPkt(input int i, input int dest, input int len);
        logic [DW-1:0] dat;
        for (int k = 0; k < len; k++) begin
            dat = $urandom();
            if (k == 0) dat[DLSB +: 8] = 8'(dest);
            pend[i].push_back({dat, k == 0, k == len - 1});
        end
    endtask

    // Random packet: mostly legal destinations, some illegal ones, some
    // missing their SOP, and occasional stray SOP flags mid-packet.
    task automatic genPacket(input int i);
        int            len;
        int            kind;
        logic [7:0]    d;
        logic [DW-1:0] dat;
        logic          sop;
        len  = $urandom_range(6, 1);
        kind = $urandom_range(99, 0);
        d    = (kind < 10) ? 8'($urandom_range(255, N)) : 8'($urandom_range(N - 1, 0));
        for (int k = 0; k < len; k++) begin
            dat = $urandom();
            if (k == 0) begin
                dat[DLSB +: 8] = d;
                sop = (kind < 95);
            end else begin
                sop = ($urandom_range(99, 0) < 5);
            end
            pend[i].push_back({dat, sop, k == len - 1});
        end
    endtask

    // Per-cycle driver: retire accepted words, present the next one (held
    // while stalled), and randomise rd_en and idle-lane junk.
    task automatic applyStimulus();
        logic [DW+1:0] w;
        for (int i = 0; i < N; i++) begin
            if (curValid[i] && mAccept[i]) begin
                void'(pend[i].pop_front());
                curValid[i] = 1'b0;
            end
            if (!curValid[i]) begin
                if (flood && i == 0) begin
                    if (pend[i].size() == 0) pend[i].push_back({DW'($urandom()), 1'b0, 1'($urandom())});
                    curValid[i] = 1'b1;
                end else begin
                    if (pend[i].size() == 0 && genOn) genPacket(i);
                    if (pend[i].size() > 0 && $urandom_range(99, 0) >= gapPct) curValid[i] = 1'b1;
                end
            end
            if (curValid[i]) begin
                w = pend[i][0];
                in_data[i*DW +: DW] = w[DW+1:2];
                in_sop[i]           = w[1];
                in_eop[i]           = w[0];
            end else begin
                in_data[i*DW +: DW] = $urandom();
                in_sop[i]           = 1'($urandom());
                in_eop[i]           = 1'($urandom());
            end
        end
        in_valid = curValid;
        for (int o = 0; o < N; o++) begin
            rd_en[o] = ($urandom_range(99, 0) < rdPct);
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            applyStimulus();
        end
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) pend[i].delete();
        curValid = '0;
        repeat (3) begin
            in_valid = N'($urandom());
            in_sop   = N'($urandom());
            in_eop   = N'($urandom());
            in_data  = {N{32'($urandom())}};
            rd_en    = N'($urandom());
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        in_valid = '0;
        rd_en    = '0;
    endtask

    initial begin
        rst      = 1'b0;
        in_data  = '0;
        in_valid = '0;
        in_sop   = '0;
        in_eop   = '0;
        rd_en    = '0;
        curValid = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] single packet to output 1");
        rdPct = 100;
        gapPct = 0;
        pushPkt(0, 1, 3);
        runCycles(10);

        $display("[TB] contention on output 0");
        pushPkt(0, 0, 4); pushPkt(1, 0, 4);
        pushPkt(0, 0, 4); pushPkt(1, 0, 4);
        runCycles(30);

        $display("[TB] output FIFO fills without rd_en");
        rdPct = 0;
        pushPkt(2, 0, 6);
        runCycles(10);
        rdPct = 30;
        runCycles(30);

        $display("[TB] invalid destination, orphan word, then legal packet");
        rdPct = 100;
        pushPkt(0, 5, 3);
        pushPkt(0, 2, 2);
        pend[1].push_back({32'h0000_0055, 1'b0, 1'b0});
        pushPkt(1, 200, 1);
        runCycles(15);

        $display("[TB] random traffic");
        genOn = 1'b1;
        gapPct = 20;
        rdPct = 70;
        runCycles(1500);
        rdPct = 20;
        runCycles(800);

        $display("[TB] reset in mid traffic");
        applyReset();
        rdPct = 60;
        gapPct = 10;
        runCycles(800);

        genOn = 1'b0;
        rdPct = 100;
        runCycles(60);

        $display("[TB] error counter saturation");
        flood = 1'b1;
        genOn = 1'b1;
        rdPct = 80;
        runCycles(65600);

        flood = 1'b0;
        genOn = 1'b0;
        rdPct = 100;
        runCycles(60);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
